// File: rtl/mem_burst_responder_pkg.sv
// ---------------------------------------------------------------------------
// mem_burst_responder_pkg
// Shared constants and types for the memory burst responder: beat width,
// burst geometry, FSM state encoding and request direction codes.
// ---------------------------------------------------------------------------
package mem_burst_responder_pkg;

  localparam int MEM_DATA_BITS = 128;
  localparam int BURST_BEATS   = 4;
  localparam int BEAT_SEL_BITS = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_RD_BURST = 2'd2,
    ST_WR_DATA  = 2'd3
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_beat_array.sv
// ---------------------------------------------------------------------------
// mem_beat_array
// Synchronous single-port storage of 2**DEPTH_BITS beats, byte-masked write
// and registered read. Contents are never cleared; only the read register
// is cleared by i_clr so the response bus idles at zero after reset.
//
// Ports:
//   clk      clock
//   i_clr    synchronous clear of the read register
//   i_we     write enable (masked by i_wmask)
//   i_re     read enable; o_rdata updates at the next edge
//   i_addr   beat index
//   i_wdata  write beat
//   i_wmask  byte enables, 1 = write that byte
//   o_rdata  registered read beat, held when i_re is low
// ---------------------------------------------------------------------------
module mem_beat_array #(
  parameter int DATA_BITS  = mem_burst_responder_pkg::MEM_DATA_BITS,
  parameter int DEPTH_BITS = 10
) (
  input  logic                   clk,
  input  logic                   i_clr,
  input  logic                   i_we,
  input  logic                   i_re,
  input  logic [DEPTH_BITS-1:0]  i_addr,
  input  logic [DATA_BITS-1:0]   i_wdata,
  input  logic [DATA_BITS/8-1:0] i_wmask,
  output logic [DATA_BITS-1:0]   o_rdata
);

  localparam int BYTES = DATA_BITS / 8;

  logic [DATA_BITS-1:0] r_mem [2**DEPTH_BITS];
  logic [DATA_BITS-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (i_wmask[b]) begin
          r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_burst_responder.sv
// ---------------------------------------------------------------------------
// mem_burst_responder
// Memory-side endpoint for the cache request interface. Accepts one line
// request at a time and returns (read) or absorbs (write) a fixed 4-beat
// burst. Read beats start LATENCY cycles after request acceptance and carry
// no back-pressure.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mem_req_val/rdy       request handshake
//   mem_req_addr          beat address (low 2 bits ignored, line aligned)
//   mem_req_rw            1 = write, 0 = read
//   mem_req_data_valid/ready, mem_req_data_bits, mem_req_data_mask
//                         write-data beats with byte enables
//   mem_resp_val          read beat valid (4 consecutive cycles)
//   mem_resp_data         registered read beat, held while not valid
// ---------------------------------------------------------------------------
module mem_burst_responder #(
  parameter int MEM_DATA_BITS = mem_burst_responder_pkg::MEM_DATA_BITS,
  parameter int MEM_ADDR_BITS = 28,
  parameter int DEPTH_BITS    = 10,
  parameter int LATENCY       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_req_val,
  output logic                       mem_req_rdy,
  input  logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
  input  logic                       mem_req_rw,
  input  logic                       mem_req_data_valid,
  output logic                       mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                       mem_resp_val,
  output logic [MEM_DATA_BITS-1:0]   mem_resp_data
);

  import mem_burst_responder_pkg::*;

  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LINE_W = DEPTH_BITS - BEAT_SEL_BITS;
  localparam logic [BEAT_SEL_BITS-1:0] LAST_BEAT = BEAT_SEL_BITS'(BURST_BEATS - 1);

  state_t                   r_state, w_state_nxt;
  logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
  logic [BEAT_SEL_BITS-1:0] r_beat, w_beat_nxt;
  logic [LINE_W-1:0]        r_line;

  logic                     w_req_fire;
  logic                     w_data_fire;
  logic                     w_arr_we;
  logic                     w_arr_re;
  logic [LINE_W-1:0]        w_arr_line;
  logic [BEAT_SEL_BITS-1:0] w_arr_beat;
  logic                     w_unused_addr;

  // Address bits above the stored range alias by design, and the beat
  // select bits are replaced by the burst counter.
  assign w_unused_addr = ^{mem_req_addr[MEM_ADDR_BITS-1:DEPTH_BITS],
                           mem_req_addr[BEAT_SEL_BITS-1:0]};

  // Handshakes are gated by reset so a request or data beat presented while
  // reset is high is never taken.
  assign mem_req_rdy        = (r_state == ST_IDLE)     && !reset;
  assign mem_req_data_ready = (r_state == ST_WR_DATA)  && !reset;
  assign mem_resp_val       = (r_state == ST_RD_BURST) && !reset;

  assign w_req_fire  = mem_req_val && mem_req_rdy;
  assign w_data_fire = mem_req_data_valid && mem_req_data_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  // Line address only; the beat offset comes from r_beat.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_line <= mem_req_addr[DEPTH_BITS-1:BEAT_SEL_BITS];
    end
  end

  // The array read is issued one cycle before each beat is presented so
  // its registered output is mem_resp_data without an extra stage.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_beat_nxt  = r_beat;
    w_arr_we    = 1'b0;
    w_arr_re    = 1'b0;
    w_arr_line  = r_line;
    w_arr_beat  = r_beat;
    case (r_state)
      ST_IDLE: begin
        if (w_req_fire) begin
          w_beat_nxt = '0;
          case (mem_req_rw)
            RW_WRITE: w_state_nxt = ST_WR_DATA;
            RW_READ: begin
              if (LATENCY == 1) begin
                // No wait state: fetch beat 0 straight from the request.
                w_state_nxt = ST_RD_BURST;
                w_arr_re    = 1'b1;
                w_arr_line  = mem_req_addr[DEPTH_BITS-1:BEAT_SEL_BITS];
                w_arr_beat  = '0;
              end else begin
                w_state_nxt = ST_RD_WAIT;
                w_cnt_nxt   = CNT_W'(LATENCY - 1);
              end
            end
            default: w_state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_RD_WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_RD_BURST;
          w_arr_re    = 1'b1;
          w_arr_beat  = '0;
        end
      end
      ST_RD_BURST: begin
        w_beat_nxt = r_beat + 1'b1;
        if (r_beat == LAST_BEAT) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_arr_re   = 1'b1;
          w_arr_beat = r_beat + 1'b1;
        end
      end
      ST_WR_DATA: begin
        if (w_data_fire) begin
          w_arr_we   = 1'b1;
          w_beat_nxt = r_beat + 1'b1;
          if (r_beat == LAST_BEAT) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  mem_beat_array #(
    .DATA_BITS  (MEM_DATA_BITS),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_array (
    .clk     (clk),
    .i_clr   (reset),
    .i_we    (w_arr_we),
    .i_re    (w_arr_re),
    .i_addr  ({w_arr_line, w_arr_beat}),
    .i_wdata (mem_req_data_bits),
    .i_wmask (mem_req_data_mask),
    .o_rdata (mem_resp_data)
  );

endmodule
